// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel clock-enable, h/v counters,
// blanking, syncs and strobes with frame-aligned NTSC/PAL/scandouble switching.
module video_timing_gen #(
  parameter int CE_DIV    = 4,
  parameter int H_ACTIVE  = 320,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 32,
  parameter int H_BP      = 32,
  parameter int NV_ACTIVE = 240,
  parameter int NV_FP     = 3,
  parameter int NV_SYNC   = 3,
  parameter int NV_BP     = 16,
  parameter int PV_ACTIVE = 288,
  parameter int PV_FP     = 3,
  parameter int PV_SYNC   = 3,
  parameter int PV_BP     = 18,
  parameter int HW        = 10,
  parameter int VW        = 10
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          pal,
  input  logic          scandouble,
  output logic          ce_pix,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          HBlank,
  output logic          VBlank,
  output logic          HSync,
  output logic          VSync,
  output logic          line_start,
  output logic          frame_start,
  output logic          pal_active,
  output logic          sd_active
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int NV_TOTAL = NV_ACTIVE + NV_FP + NV_SYNC + NV_BP;
  localparam int PV_TOTAL = PV_ACTIVE + PV_FP + PV_SYNC + PV_BP;
  localparam int CW       = $clog2(CE_DIV);
  localparam int VLW      = VW + 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_B   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_E   = HW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [VW-1:0] NV_A  = VW'(NV_ACTIVE);
  localparam logic [VW-1:0] NVS_B = VW'(NV_ACTIVE + NV_FP);
  localparam logic [VW-1:0] NVS_E = VW'(NV_ACTIVE + NV_FP + NV_SYNC);
  localparam logic [VW-1:0] PV_A  = VW'(PV_ACTIVE);
  localparam logic [VW-1:0] PVS_B = VW'(PV_ACTIVE + PV_FP);
  localparam logic [VW-1:0] PVS_E = VW'(PV_ACTIVE + PV_FP + PV_SYNC);

  localparam logic [VLW-1:0] NV_L1 = VLW'(NV_TOTAL - 1);
  localparam logic [VLW-1:0] NV_L2 = VLW'(2 * NV_TOTAL - 1);
  localparam logic [VLW-1:0] PV_L1 = VLW'(PV_TOTAL - 1);
  localparam logic [VLW-1:0] PV_L2 = VLW'(2 * PV_TOTAL - 1);

  localparam logic [CW-1:0] D_N = CW'(CE_DIV - 1);
  localparam logic [CW-1:0] D_S = CW'(CE_DIV / 2 - 1);

  logic [CW-1:0]  cd;
  logic [CW-1:0]  d_max;
  logic [VLW-1:0] vl;
  logic [VLW-1:0] vl_max;
  logic [VLW-1:0] vl_n;
  logic [HW-1:0]  h_n;
  logic [VW-1:0]  v_n;
  logic [VW-1:0]  v_act;
  logic [VW-1:0]  vs_b;
  logic [VW-1:0]  vs_e;
  logic           h_wrap;
  logic           f_wrap;
  logic           pal_n;
  logic           sd_n;

  // Divider limit follows the mode in effect; >= compare absorbs a shrink mid-count.
  always_comb begin
    d_max = sd_active ? D_S : D_N;
  end

  // Pixel clock-enable divider.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cd     <= '0;
      ce_pix <= 1'b0;
    end else if (cd >= d_max) begin
      cd     <= '0;
      ce_pix <= 1'b1;
    end else begin
      cd     <= cd + 1'b1;
      ce_pix <= 1'b0;
    end
  end

  // Next counter values, mode latch at the frame wrap, and flag thresholds.
  always_comb begin
    h_wrap = (hcount == H_LAST);
    unique case ({pal_active, sd_active})
      2'b00:   vl_max = NV_L1;
      2'b01:   vl_max = NV_L2;
      2'b10:   vl_max = PV_L1;
      default: vl_max = PV_L2;
    endcase
    f_wrap = h_wrap && (vl == vl_max);
    pal_n  = f_wrap ? pal : pal_active;
    sd_n   = f_wrap ? scandouble : sd_active;
    h_n    = h_wrap ? '0 : hcount + 1'b1;
    vl_n   = vl;
    if (f_wrap)
      vl_n = '0;
    else if (h_wrap)
      vl_n = vl + 1'b1;
    v_n   = sd_n ? VW'(vl_n >> 1) : VW'(vl_n);
    v_act = pal_n ? PV_A  : NV_A;
    vs_b  = pal_n ? PVS_B : NVS_B;
    vs_e  = pal_n ? PVS_E : NVS_E;
  end

  // Counters, flags and strobes all load on the same pixel edge.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hcount      <= '0;
      vl          <= '0;
      vcount      <= '0;
      HBlank      <= 1'b0;
      VBlank      <= 1'b0;
      HSync       <= 1'b0;
      VSync       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      pal_active  <= 1'b0;
      sd_active   <= 1'b0;
    end else if (ce_pix) begin
      hcount      <= h_n;
      vl          <= vl_n;
      vcount      <= v_n;
      HBlank      <= (h_n >= H_ACT);
      HSync       <= (h_n >= HS_B) && (h_n < HS_E);
      VBlank      <= (v_n >= v_act);
      VSync       <= (v_n >= vs_b) && (v_n < vs_e);
      line_start  <= h_wrap;
      frame_start <= f_wrap;
      pal_active  <= pal_n;
      sd_active   <= sd_n;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor to the fixed NTSC/PAL raster timing used by the core video path.
- Generates the pixel clock-enable, the h/v counters, blanking and syncs for the emu-level VGA_* outputs.
- Supports:
  - Independent NTSC and PAL vertical geometries.
  - Scandoubled mode: pixel rate doubled, line count doubled.
  - Mode switching that is glitch-free and frame-aligned.
  - Frame/line strobes for downstream renderers.

Parameters:
- CE_DIV, 4, clk_sys cycles per pixel in normal mode; even, >=2.
- H_ACTIVE, 320, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 32, HSync width, in pixels.
- H_BP, 32, horizontal back porch, in pixels.
- NV_ACTIVE, 240, NTSC visible lines.
- NV_FP, 3, NTSC vertical front porch, in lines.
- NV_SYNC, 3, NTSC VSync width, in lines.
- NV_BP, 16, NTSC vertical back porch, in lines.
- PV_ACTIVE, 288, PAL visible lines.
- PV_FP, 3, PAL vertical front porch, in lines.
- PV_SYNC, 3, PAL VSync width, in lines.
- PV_BP, 18, PAL vertical back porch, in lines.
- HW, 10, hcount width; must hold H_TOTAL-1.
- VW, 10, vcount width; must hold the largest V_TOTAL-1.

Ports:
- clk_sys, in, 1, system clock.
- reset, in, 1, asynchronous, active-high.
- pal, in, 1, requested mode: 1 = PAL, 0 = NTSC.
- scandouble, in, 1, requested scandoubled output.
- ce_pix, out, 1, pixel clock-enable, one clk_sys wide.
- hcount, out, HW, current pixel column.
- vcount, out, VW, current source line.
- HBlank, out, 1, horizontal blanking.
- VBlank, out, 1, vertical blanking.
- HSync, out, 1, horizontal sync, active-high.
- VSync, out, 1, vertical sync, active-high.
- line_start, out, 1, one-clk strobe at hcount 0.
- frame_start, out, 1, one-clk strobe at hcount 0, vcount 0.
- pal_active, out, 1, mode currently in effect.
- sd_active, out, 1, scandouble currently in effect.

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 400).
  - V_TOTAL = NTSC 262 / PAL 312, each the sum of its four terms.
- Reset (async): every output and every internal register is 0. This gives NTSC, non-scandoubled, counters at 0.
- Divider:
  - Divide factor D = CE_DIV normally, CE_DIV/2 when sd_active.
  - Counter cd counts 0..D-1 and wraps.
  - ce_pix is registered and high exactly one cycle in D.
  - The first ce_pix after reset release is high after the D-th rising edge.
- Counters advance only on clk_sys edges where ce_pix=1.
  - hcount counts 0..H_TOTAL-1, then wraps to 0.
  - At the hcount wrap, internal line counter vl increments.
  - vl range: 0..V_TOTAL-1 normally; 0..2*V_TOTAL-1 when sd_active.
  - vcount = vl normally; vcount = vl>>1 when sd_active, so each source line is emitted twice.
- All flags are registered and update on the same edge as hcount/vcount, so they are always coherent with the counter outputs:
  - HBlank = hcount >= H_ACTIVE.
  - HSync = H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
  - VBlank = vcount >= V_ACTIVE.
  - VSync = V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, using the geometry of pal_active.
- Strobes:
  - line_start is high for the single clk_sys cycle in which hcount has just become 0.
  - frame_start is high when hcount and vcount have both just become 0.
  - Neither strobe asserts out of reset; the first assertion is at the first frame wrap.
- Mode change:
  - pal and scandouble are sampled into pal_active/sd_active only on the frame-wrap edge, i.e. the ce_pix edge leaving the last pixel of the last line.
  - The new D takes effect from the next cd wrap.
  - Mid-frame input changes have no effect on the current frame.
  - Toggling inputs and restoring them before the wrap leaves the mode unchanged.
- Simultaneous mode changes: if pal and scandouble change together, both take effect at the same wrap.
- Reset mid-frame: outputs clear immediately (asynchronously). Counting restarts from 0 in NTSC single mode.
- Scandoubled frame period equals normal frame period, since the pixel rate and line count are both doubled.

Test Plan:
- Reset, then pal=0, sd=0 for 2 frames:
  - frame_start period is 419200 clk.
  - line_start period is 1600 clk.
  - HSync high for hcount 336..367 (128 clk per line).
  - VSync high for vcount 243..245.
  - VBlank rises at vcount 240.
- Set pal=1 mid-frame:
  - pal_active stays 0 until the next frame_start, then becomes 1.
  - Following frame is 499200 clk, VSync at vcount 291..293, VBlank from vcount 288.
- Set scandouble=1:
  - After the next wrap, ce_pix period is 2 clk.
  - Each vcount value spans 2 lines (1600 clk in total).
  - frame period is still 419200 clk (NTSC).
- Pulse pal high then low within a frame: pal_active never changes; frame period stays constant.
- Assert reset at hcount=200, vcount=100 for 3 clk:
  - All outputs are 0 while reset is asserted.
  - After release, the first ce_pix appears at the 4th edge; hcount then counts 1, 2, ...
- Change pal and scandouble together: both active bits flip at the same frame_start edge; no runt HSync or ce_pix pulse occurs at the boundary.
